// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path.
// Contents:
//   UART_DATA_W        - byte width produced by the UART receiver
//   UART_RX_FIFO_DEPTH - default number of entries in the receive FIFO
//   fifo_op_e / fifo_op - classification of what the FIFO does in one cycle
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  // Per-cycle FIFO activity. The encoding is {read, write}, which lets
  // fifo_op() build the value straight from the two qualified strobes.
  typedef enum logic [1:0] {
    FIFO_OP_IDLE  = 2'b00,
    FIFO_OP_WRITE = 2'b01,
    FIFO_OP_READ  = 2'b10,
    FIFO_OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic do_wr, input logic do_rd);
    return fifo_op_e'({do_rd, do_wr});
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver / consumer and the receive FIFO.
// Signals:
//   rx_ready, rx_data       - receiver frame-done level and byte
//   rd_en, clr_ovf          - consumer read request and overflow clear
//   rd_data, rd_valid       - registered read result and its one-cycle strobe
//   empty, full, count      - occupancy status
//   overflow                - sticky dropped-byte flag
// Modports:
//   master - the side driving the receiver/consumer signals
//   slave  - the FIFO itself
interface uart_rx_fifo_if #(
  parameter int DATA_W = uart_pkg::UART_DATA_W,
  parameter int DEPTH  = uart_pkg::UART_RX_FIFO_DEPTH
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output rx_ready, rx_data, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  rx_ready, rx_data, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage array for the receive FIFO.
// Ports:
//   clk, rst        - clock and synchronous active-high reset (read register only)
//   we, waddr, wdata - write port
//   re, raddr, rdata - registered read port; rdata holds when re is low
// A read and a write to the same address in one cycle return the old
// contents, which the full-FIFO simultaneous read/write case relies on.
module uart_fifo_mem #(
  parameter int DEPTH  = uart_pkg::UART_RX_FIFO_DEPTH,
  parameter int DATA_W = uart_pkg::UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are never reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer sitting directly behind the UART receiver.
// A rising edge of rx_ready marks a completed frame; the byte is captured
// one cycle later (giving the receiver's registered data output time to
// settle) and pushed into a circular FIFO. The consumer pops bytes with
// rd_en and sees them on rd_data with a one-cycle rd_valid strobe.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - uart_rx_fifo_if slave modport (receiver, consumer and status signals)
module uart_rx_fifo #(
  parameter int DEPTH  = uart_pkg::UART_RX_FIFO_DEPTH,
  parameter int DATA_W = uart_pkg::UART_DATA_W
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);

  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic              rdy_q_reg;
  logic              wr_pend_reg;
  logic              rise;
  logic [AW-1:0]     wptr_reg, wptr_next;
  logic [AW-1:0]     rptr_reg, rptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              ovf_reg, ovf_next;
  logic              rd_valid_reg;
  logic              empty, full;
  logic              do_wr, do_rd, drop;
  logic [DATA_W-1:0] rd_data_w;
  fifo_op_e          op;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);

  // Only the first cycle of a ready level counts as a frame.
  assign rise = bus.rx_ready & ~rdy_q_reg;

  // A full FIFO still accepts a byte when a read frees a slot in the same
  // cycle; full implies non-empty, so that read is always honoured.
  assign do_rd = bus.rd_en & ~empty;
  assign do_wr = wr_pend_reg & (~full | bus.rd_en);
  assign drop  = wr_pend_reg & full & ~bus.rd_en;
  assign op    = fifo_op(do_wr, do_rd);

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;

    if (do_wr) begin
      wptr_next = wptr_reg + AW'(1);
    end
    if (do_rd) begin
      rptr_next = rptr_reg + AW'(1);
    end

    case (op)
      FIFO_OP_WRITE: count_next = count_reg + CW'(1);
      FIFO_OP_READ:  count_next = count_reg - CW'(1);
      default:       count_next = count_reg;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_next = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q_reg    <= 1'b0;
      wr_pend_reg  <= 1'b0;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      ovf_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      rdy_q_reg    <= bus.rx_ready;
      wr_pend_reg  <= rise;
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      count_reg    <= count_next;
      ovf_reg      <= ovf_next;
      rd_valid_reg <= do_rd;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (do_wr),
    .waddr (wptr_reg),
    .wdata (bus.rx_data),
    .re    (do_rd),
    .raddr (rptr_reg),
    .rdata (rd_data_w)
  );

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_reg;
  assign bus.overflow = ovf_reg;

endmodule
